// File: rtl/qnigma_poly1305_pkg.sv
// Shared Poly1305 constants and types for the controller and the multiply-reduce core.
package qnigma_poly1305_pkg;

  localparam int BLOCK_BYTES = 17;
  localparam logic [129:0] P1305 = {2'b11, 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb};
  localparam logic [127:0] R_CLAMP = 128'h0fff_fffc_0fff_fffc_0fff_fffc_0fff_ffff;

  typedef logic [BLOCK_BYTES-1:0][7:0] poly_blk_t;
  typedef logic [15:0][7:0] poly_tag_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MUL   = 3'd2,
    FINAL = 3'd3,
    TAG   = 3'd4
  } poly_ctrl_state_t;

  function automatic logic [127:0] le_bytes_to_num(input logic [15:0][7:0] bytes_le);
    logic [127:0] num;
    num = '0;
    for (int i = 0; i < 16; i++) begin
      num[8*i +: 8] = bytes_le[i];
    end
    return num;
  endfunction

endpackage

// File: rtl/qnigma_poly1305_ctrl_pack.sv
// Byte packer: writes the incoming byte at position cnt and, when the block closes,
// appends the 0x01 pad byte directly above it and clears everything higher.
module qnigma_poly1305_ctrl_pack
  import qnigma_poly1305_pkg::*;
(
  input  logic [BLOCK_BYTES-1:0][7:0] blk_i,
  input  logic [3:0]                  cnt_i,
  input  logic [7:0]                  dat_i,
  input  logic                        close_i,
  output logic [BLOCK_BYTES-1:0][7:0] blk_o
);

  logic [4:0] pos_s;
  logic [4:0] pad_s;

  assign pos_s = {1'b0, cnt_i};
  assign pad_s = pos_s + 5'd1;

  always_comb begin
    blk_o = blk_i;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (5'(i) == pos_s) begin
        blk_o[i] = dat_i;
      end else if (close_i && (5'(i) == pad_s)) begin
        blk_o[i] = 8'h01;
      end else if (close_i && (5'(i) > pad_s)) begin
        blk_o[i] = 8'h00;
      end else begin
        blk_o[i] = blk_i[i];
      end
    end
  end

endmodule

// File: rtl/qnigma_poly1305_ctrl.sv
// Poly1305 sequencer: packs the byte stream into padded blocks, hands acc+blk to the
// external multiply-reduce core once per block, then adds s to form the tag.
module qnigma_poly1305_ctrl
  import qnigma_poly1305_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               key_val,
  input  logic [31:0][7:0]   key,
  input  logic               key_empty,
  input  logic               in_val,
  input  logic [7:0]         in_dat,
  input  logic               in_last,
  output logic               in_rdy,
  output logic               mul_req,
  output logic [130:0]       mul_a,
  output logic [127:0]       mul_r,
  input  logic               mul_done,
  input  logic [129:0]       mul_res,
  output logic               tag_val,
  output logic [15:0][7:0]   tag,
  output logic               busy
);

  poly_ctrl_state_t state_q, state_d;
  logic [129:0]     acc_q, acc_d;
  poly_blk_t        blk_q, blk_d;
  poly_blk_t        blk_fill;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [127:0]     r_q, r_d;
  logic [127:0]     s_q, s_d;
  poly_tag_t        tag_q, tag_d;
  logic [130:0]     mul_a_q, mul_a_d;
  logic             in_rdy_q, in_rdy_d;
  logic             mul_req_q, mul_req_d;
  logic             tag_val_q, tag_val_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             close;

  assign accept = (state_q == LOAD) && in_val && in_rdy_q;
  // A 16th byte closes the block on its own, so in_last there never adds an empty block.
  assign close  = accept && (in_last || (cnt_q == 4'd15));

  qnigma_poly1305_ctrl_pack u_pack (
    .blk_i   (blk_q),
    .cnt_i   (cnt_q),
    .dat_i   (in_dat),
    .close_i (close),
    .blk_o   (blk_fill)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    blk_d     = blk_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    r_d       = r_q;
    s_d       = s_q;
    tag_d     = tag_q;
    mul_a_d   = mul_a_q;
    in_rdy_d  = 1'b0;
    mul_req_d = 1'b0;
    tag_val_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_val) begin
          r_d    = le_bytes_to_num(key[15:0]) & R_CLAMP;
          s_d    = le_bytes_to_num(key[31:16]);
          acc_d  = '0;
          blk_d  = '0;
          cnt_d  = 4'd0;
          last_d = 1'b0;
          tag_d  = '0;
          if (key_empty) begin
            state_d = FINAL;
          end else begin
            state_d  = LOAD;
            in_rdy_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (close) begin
          blk_d     = blk_fill;
          last_d    = in_last;
          mul_a_d   = {1'b0, acc_q} + 131'(blk_fill);
          mul_req_d = 1'b1;
          state_d   = MUL;
        end else if (accept) begin
          blk_d    = blk_fill;
          cnt_d    = cnt_q + 4'd1;
          in_rdy_d = 1'b1;
        end else begin
          in_rdy_d = 1'b1;
        end
      end
      MUL: begin
        if (mul_done) begin
          acc_d = mul_res;
          blk_d = '0;
          cnt_d = 4'd0;
          if (last_q) begin
            state_d = FINAL;
          end else begin
            state_d  = LOAD;
            in_rdy_d = 1'b1;
          end
        end else begin
          state_d = MUL;
        end
      end
      FINAL: begin
        tag_d     = acc_q[127:0] + s_q;
        tag_val_d = 1'b1;
        state_d   = TAG;
      end
      TAG: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      blk_q     <= '0;
      cnt_q     <= 4'd0;
      last_q    <= 1'b0;
      r_q       <= '0;
      s_q       <= '0;
      tag_q     <= '0;
      mul_a_q   <= '0;
      in_rdy_q  <= 1'b0;
      mul_req_q <= 1'b0;
      tag_val_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      blk_q     <= blk_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      r_q       <= r_d;
      s_q       <= s_d;
      tag_q     <= tag_d;
      mul_a_q   <= mul_a_d;
      in_rdy_q  <= in_rdy_d;
      mul_req_q <= mul_req_d;
      tag_val_q <= tag_val_d;
      busy_q    <= busy_d;
    end
  end

  assign in_rdy  = in_rdy_q;
  assign mul_req = mul_req_q;
  assign mul_a   = mul_a_q;
  assign mul_r   = r_q;
  assign tag_val = tag_val_q;
  assign tag     = tag_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_qnigma_poly1305_ctrl.sv
// Bench for qnigma_poly1305_ctrl: behavioural mulred with programmable latency and a
// plain-arithmetic Poly1305 reference model.
module tb_qnigma_poly1305_ctrl;

  typedef logic [7:0] bq_t[$];

  localparam logic [130:0] P_WIDE = (131'd1 << 130) - 131'd5;
  localparam logic [127:0] CLAMP  = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
  localparam logic [7:0] RFC_KB [32] = '{
    8'h85, 8'hd6, 8'hbe, 8'h78, 8'h57, 8'h55, 8'h6d, 8'h33,
    8'h7f, 8'h44, 8'h52, 8'hfe, 8'h42, 8'hd5, 8'h06, 8'ha8,
    8'h01, 8'h03, 8'h80, 8'h8a, 8'hfb, 8'h0d, 8'hb2, 8'hfd,
    8'h4a, 8'hbf, 8'hf6, 8'haf, 8'h41, 8'h49, 8'hf5, 8'h1b};
  localparam logic [7:0] RFC_TB [16] = '{
    8'ha8, 8'h06, 8'h1d, 8'hc1, 8'h30, 8'h51, 8'h36, 8'hc6,
    8'hc2, 8'h2b, 8'h8b, 8'haf, 8'h0c, 8'h01, 8'h27, 8'ha9};

  logic             clk;
  logic             rst;
  logic             key_val;
  logic [31:0][7:0] key;
  logic             key_empty;
  logic             in_val;
  logic [7:0]       in_dat;
  logic             in_last;
  logic             in_rdy;
  logic             mul_req;
  logic [130:0]     mul_a;
  logic [127:0]     mul_r;
  logic             mul_done;
  logic [129:0]     mul_res;
  logic             tag_val;
  logic [15:0][7:0] tag;
  logic             busy;

  qnigma_poly1305_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_val   (key_val),
    .key       (key),
    .key_empty (key_empty),
    .in_val    (in_val),
    .in_dat    (in_dat),
    .in_last   (in_last),
    .in_rdy    (in_rdy),
    .mul_req   (mul_req),
    .mul_a     (mul_a),
    .mul_r     (mul_r),
    .mul_done  (mul_done),
    .mul_res   (mul_res),
    .tag_val   (tag_val),
    .tag       (tag),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // environment state shared with the main sequence
  int           lat = 1;
  int           cd = 0;
  logic [130:0] a_cap = '0;
  logic [127:0] r_cap = '0;
  bit           no_chk = 1'b0;
  bit           rdy_prev = 1'b0;
  int           req_cnt = 0;
  int           tv_cnt = 0;
  int           tv_cyc = -100;
  int           done_cyc = -100;
  int           acc_cyc = -100;
  int           t_key = -100;
  logic [127:0] tag_seen = '0;
  int           inrdy_bad = 0;
  int           stable_bad = 0;
  int           req_bad = 0;
  int           rise_bad = 0;
  int           tv_bad = 0;

  function automatic logic [129:0] mulmod(input logic [130:0] a, input logic [127:0] r);
    logic [258:0] prod;
    prod = 259'(a) * 259'(r);
    return 130'(prod % 259'(P_WIDE));
  endfunction

  function automatic logic [127:0] poly_ref(input logic [31:0][7:0] k, input bq_t m);
    logic [127:0] r;
    logic [127:0] s;
    logic [129:0] h;
    logic [130:0] n;
    int len;
    for (int j = 0; j < 16; j++) begin
      r[8*j +: 8] = k[j];
      s[8*j +: 8] = k[16+j];
    end
    r = r & CLAMP;
    h = '0;
    for (int i = 0; i < m.size(); i += 16) begin
      len = ((m.size() - i) < 16) ? (m.size() - i) : 16;
      n = '0;
      for (int j = 0; j < len; j++) n[8*j +: 8] = m[i+j];
      n[8*len] = 1'b1;
      h = mulmod(131'(h) + n, r);
    end
    return h[127:0] + s;
  endfunction

  function automatic logic [31:0][7:0] rand_key();
    logic [31:0][7:0] k;
    for (int j = 0; j < 32; j++) k[j] = 8'($urandom);
    return k;
  endfunction

  function automatic bq_t rand_msg(input int len);
    bq_t m;
    for (int j = 0; j < len; j++) m.push_back(8'($urandom));
    return m;
  endfunction

  task automatic chk(input string nm, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observe DUT at negedge, then advance the behavioural multiply-reduce core.
  initial begin
    mul_done = 1'b0;
    mul_res  = '0;
    forever begin
      @(negedge clk);
      if (tag_val) begin
        tv_cnt++;
        tv_cyc   = cyc;
        tag_seen = tag;
        if (cyc != done_cyc + 2 && cyc != t_key + 2) tv_bad++;
      end
      if (in_rdy && !rdy_prev && cyc != done_cyc + 1 && cyc != t_key + 1) rise_bad++;
      rdy_prev = in_rdy;
      if (rst && cd > 0) no_chk = 1'b1;
      if (cd > 0 && !no_chk) begin
        if (in_rdy) inrdy_bad++;
        if (mul_a !== a_cap || mul_r !== r_cap) stable_bad++;
      end
      if (mul_req) begin
        req_cnt++;
        if (in_rdy) inrdy_bad++;
        if (cyc != acc_cyc + 1) req_bad++;
        a_cap  = mul_a;
        r_cap  = mul_r;
        no_chk = 1'b0;
      end
      if (in_val && in_rdy && !rst) acc_cyc = cyc;
      mul_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mul_done = 1'b1;
          mul_res  = mulmod(a_cap, r_cap);
          done_cyc = cyc;
        end
      end
      if (mul_req) cd = lat;
    end
  end

  task automatic run_msg(input logic [31:0][7:0] k, input bit empty, input bq_t m,
                         input int lat_i, input int gap_pct, input bit poke,
                         output logic [127:0] got, output int nreq);
    int idx;
    int budget;
    int req0;
    int tv0;
    lat  = lat_i;
    req0 = req_cnt;
    tv0  = tv_cnt;
    @(posedge clk); #1;
    key = k; key_empty = empty; key_val = 1'b1; t_key = cyc;
    @(posedge clk); #1;
    key_val = 1'b0; key = rand_key(); key_empty = 1'b0;
    idx = 0;
    budget = 5000;
    while (!empty && idx < m.size() && budget > 0) begin
      in_val  = ($urandom_range(99) >= 32'(gap_pct));
      in_dat  = m[idx];
      in_last = (idx == m.size() - 1);
      if (poke && ($urandom_range(3) == 0)) begin
        key_val = 1'b1; key = rand_key(); key_empty = 1'($urandom_range(1));
      end else begin
        key_val = 1'b0;
      end
      @(negedge clk);
      if (in_val && in_rdy) idx++;
      @(posedge clk); #1;
      budget--;
    end
    in_val = 1'b0; in_last = 1'b0; key_val = 1'b0; key_empty = 1'b0;
    chk("bytes_accepted", 256'(idx), 256'(empty ? 0 : m.size()));
    budget = 2000;
    while (tv_cnt == tv0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("tag_val_pulses", 256'(tv_cnt - tv0), 256'(1));
    got  = tag_seen;
    nreq = req_cnt - req0;
  endtask

  logic [31:0][7:0] rfc_key;
  logic [31:0][7:0] k;
  logic [127:0]     rfc_tag;
  logic [127:0]     rfc_s;
  logic [127:0]     exp_tag;
  logic [127:0]     got;
  bq_t              rfc_msg;
  bq_t              m;
  bq_t              none;
  int               nreq;
  int               len;
  int               tv0;
  int               req0;
  string            txt;

  initial begin
    rst = 1'b1; key_val = 1'b0; key = '0; key_empty = 1'b0;
    in_val = 1'b0; in_dat = 8'h00; in_last = 1'b0;
    for (int j = 0; j < 32; j++) rfc_key[j] = RFC_KB[j];
    for (int j = 0; j < 16; j++) rfc_tag[8*j +: 8] = RFC_TB[j];
    for (int j = 0; j < 16; j++) rfc_s[8*j +: 8] = RFC_KB[16+j];
    txt = "Cryptographic Forum Research Group";
    for (int j = 0; j < txt.len(); j++) rfc_msg.push_back(txt[j]);

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", 256'(in_rdy), 256'(0));
    chk("rst_mul_req", 256'(mul_req), 256'(0));
    chk("rst_tag_val", 256'(tag_val), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_mul_a", 256'(mul_a), 256'(0));
    chk("rst_mul_r", 256'(mul_r), 256'(0));
    chk("rst_tag", 256'(tag), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // RFC 8439 vector
    run_msg(rfc_key, 1'b0, rfc_msg, 3, 0, 1'b0, got, nreq);
    chk("rfc_tag", 256'(got), 256'(rfc_tag));
    chk("rfc_tag_model", 256'(got), 256'(poly_ref(rfc_key, rfc_msg)));
    chk("rfc_mul_reqs", 256'(nreq), 256'(3));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rfc_tag_hold", 256'(tag), 256'(rfc_tag));
    chk("idle_busy", 256'(busy), 256'(0));

    // empty message
    run_msg(rfc_key, 1'b1, none, 5, 0, 1'b0, got, nreq);
    chk("empty_tag", 256'(got), 256'(rfc_s));
    chk("empty_mul_reqs", 256'(nreq), 256'(0));
    chk("empty_latency", 256'(tv_cyc - t_key), 256'(2));

    // exactly 16 bytes with in_last on byte 16
    k = rand_key();
    m = rand_msg(16);
    run_msg(k, 1'b0, m, 7, 0, 1'b0, got, nreq);
    chk("b16_mul_reqs", 256'(nreq), 256'(1));
    chk("b16_mul_a_bit128", 256'(a_cap[128]), 256'(1));
    chk("b16_tag", 256'(got), 256'(poly_ref(k, m)));

    // random gaps, extreme latencies, key_val pulsed while busy
    for (int li = 0; li < 2; li++) begin
      for (int rep = 0; rep < 3; rep++) begin
        k   = rand_key();
        len = int'($urandom_range(70, 1));
        m   = rand_msg(len);
        run_msg(k, 1'b0, m, (li == 0) ? 1 : 40, 40, 1'b1, got, nreq);
        chk("rand_tag", 256'(got), 256'(poly_ref(k, m)));
        chk("rand_mul_reqs", 256'(nreq), 256'((len + 15) / 16));
      end
    end

    // r all ones -> clamped r
    k = rand_key();
    for (int j = 0; j < 16; j++) k[j] = 8'hff;
    m = rand_msg(20);
    run_msg(k, 1'b0, m, 4, 20, 1'b0, got, nreq);
    chk("clamp_mul_r", 256'(r_cap), 256'(CLAMP));
    chk("clamp_tag", 256'(got), 256'(poly_ref(k, m)));

    // r zero -> tag equals s
    k = rand_key();
    for (int j = 0; j < 16; j++) k[j] = 8'h00;
    m = rand_msg(37);
    run_msg(k, 1'b0, m, 2, 20, 1'b0, got, nreq);
    for (int j = 0; j < 16; j++) exp_tag[8*j +: 8] = k[16+j];
    chk("r0_tag", 256'(got), 256'(exp_tag));

    // reset while MUL is waiting, then a stale mul_done
    lat = 40;
    @(posedge clk); #1;
    key = rfc_key; key_empty = 1'b0; key_val = 1'b1; t_key = cyc;
    @(posedge clk); #1;
    key_val = 1'b0; in_val = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_dat = rfc_msg[i]; in_last = 1'b0;
      @(posedge clk); #1;
    end
    in_val = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("pre_rst_busy", 256'(busy), 256'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mulrst_in_rdy", 256'(in_rdy), 256'(0));
    chk("mulrst_mul_req", 256'(mul_req), 256'(0));
    chk("mulrst_tag_val", 256'(tag_val), 256'(0));
    chk("mulrst_busy", 256'(busy), 256'(0));
    chk("mulrst_mul_a", 256'(mul_a), 256'(0));
    chk("mulrst_mul_r", 256'(mul_r), 256'(0));
    chk("mulrst_tag", 256'(tag), 256'(0));
    tv0  = tv_cnt;
    req0 = req_cnt;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("stale_busy", 256'(busy), 256'(0));
    chk("stale_in_rdy", 256'(in_rdy), 256'(0));
    chk("stale_tag_val", 256'(tv_cnt - tv0), 256'(0));
    chk("stale_mul_req", 256'(req_cnt - req0), 256'(0));
    chk("stale_tag", 256'(tag), 256'(0));

    run_msg(rfc_key, 1'b0, rfc_msg, 9, 30, 1'b0, got, nreq);
    chk("rfc_after_rst_tag", 256'(got), 256'(rfc_tag));
    chk("rfc_after_rst_reqs", 256'(nreq), 256'(3));

    // protocol invariants collected by the environment
    chk("in_rdy_while_mul", 256'(inrdy_bad), 256'(0));
    chk("mul_operand_stable", 256'(stable_bad), 256'(0));
    chk("mul_req_timing", 256'(req_bad), 256'(0));
    chk("in_rdy_timing", 256'(rise_bad), 256'(0));
    chk("tag_val_timing", 256'(tv_bad), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
